// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types and constants for the bit-serial magnitude comparator.
//   state_t : controller FSM states (IDLE, RUN)
//   RES_*   : result encoding as the packed vector {gt, lt, eq}
// -----------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

endpackage : cmp_pkg

// File: rtl/cmp_cell_1bit.sv
// -----------------------------------------------------------------------------
// cmp_cell_1bit
// Purely combinational 1-bit magnitude compare cell.
//   a, b : input bits
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
// -----------------------------------------------------------------------------
module cmp_cell_1bit (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);

endmodule : cmp_cell_1bit

// File: rtl/serial_mag_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// serial_mag_cmp_ctrl
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock,
// using a single shared 1-bit compare cell.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   start         : request a compare (only honoured while idle)
//   a, b          : operands, captured when start is accepted
//   busy          : compare in progress
//   done          : one-cycle completion pulse
//   gt, lt, eq    : registered result, held until the next accepted start
//   bits_examined : bit positions compared by the last operation
// -----------------------------------------------------------------------------
module serial_mag_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [CW-1:0]    bits_examined
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_idx;
  logic [CW-1:0]    r_bits;
  logic             r_sticky;
  logic             r_sticky_gt;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;

  logic             w_cell_gt;
  logic             w_cell_lt;
  logic             w_cell_eq;
  logic             w_finish;

  // The shadow operands shift left each RUN cycle, so the bit at position idx
  // is always sitting in the MSB; idx only tracks when to stop.
  cmp_cell_1bit u_cell (
    .a  (r_a[WIDTH-1]),
    .b  (r_b[WIDTH-1]),
    .gt (w_cell_gt),
    .lt (w_cell_lt),
    .eq (w_cell_eq)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        if ((EARLY_EXIT && !w_cell_eq) || (r_idx == '0)) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_bits      <= '0;
      r_sticky    <= 1'b0;
      r_sticky_gt <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a         <= a;
            r_b         <= b;
            r_idx       <= CW'(WIDTH - 1);
            r_bits      <= '0;
            r_sticky    <= 1'b0;
            r_sticky_gt <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        RUN: begin
          r_a    <= r_a << 1;
          r_b    <= r_b << 1;
          r_idx  <= r_idx - CW'(1);
          r_bits <= r_bits + CW'(1);
          // Only the first (most significant) difference decides the result.
          if (!r_sticky && !w_cell_eq) begin
            r_sticky    <= 1'b1;
            r_sticky_gt <= w_cell_gt;
          end
          if (w_finish) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            if (r_sticky) begin
              r_gt <= r_sticky_gt;
              r_lt <= ~r_sticky_gt;
              r_eq <= 1'b0;
            end else begin
              r_gt <= w_cell_gt;
              r_lt <= w_cell_lt;
              r_eq <= w_cell_eq;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign gt            = r_gt;
  assign lt            = r_lt;
  assign eq            = r_eq;
  assign bits_examined = r_bits;

endmodule : serial_mag_cmp_ctrl
